// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI TMDS symbol path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package hdmi_pkg;

    typedef logic [9:0] tmds_word_t;

    // Control-period symbols indexed by CD = {c1, c0}
    localparam tmds_word_t TMDS_CTL_00 = 10'h354;
    localparam tmds_word_t TMDS_CTL_01 = 10'h0AB;
    localparam tmds_word_t TMDS_CTL_10 = 10'h154;
    localparam tmds_word_t TMDS_CTL_11 = 10'h2AB;

    // Video guard band symbols per channel
    localparam tmds_word_t TMDS_VGB_CH0 = 10'h2CC;
    localparam tmds_word_t TMDS_VGB_CH1 = 10'h133;
    localparam tmds_word_t TMDS_VGB_CH2 = 10'h2CC;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int MIN_BLANK    = 12;
    localparam int LOOKAHEAD    = PREAMBLE_LEN + GUARD_LEN;

    // Input register + encoder register, plus the lookahead line when guards are on
    localparam int LATENCY_DVI   = 2;
    localparam int LATENCY_GUARD = LATENCY_DVI + LOOKAHEAD;

    typedef enum logic [1:0] {
        OVR_NONE     = 2'd0,
        OVR_PREAMBLE = 2'd1,
        OVR_GUARD    = 2'd2
    } ovr_sel_t;

    // One pixel slot as it travels through the input register and delay line
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    function automatic tmds_word_t ctl_word(input logic [1:0] cd);
        case (cd)
            2'b00:   return TMDS_CTL_00;
            2'b01:   return TMDS_CTL_01;
            2'b10:   return TMDS_CTL_10;
            default: return TMDS_CTL_11;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_tmds_stream_enc.sv
// One TMDS channel: DVI 8b/10b video coding, control symbols, guard override.
// Latency: 1 cycle (registered output word and running disparity).
// Backpressure: none; accepts one symbol every cycle.
module tmds_channel_encoder
    import hdmi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic [1:0] cd,
    input  logic       de,
    input  ovr_sel_t   ovr,
    input  tmds_word_t guard_word,
    output tmds_word_t tmds
);

    logic [4:0] cnt;        // running disparity, two's complement
    logic [4:0] cnt_nx;
    logic [3:0] n1d;
    logic [3:0] n1q;
    logic       use_xnor;
    logic       acc;
    logic [8:0] qm;
    logic [4:0] diff;       // N1 - N0 of qm[7:0], two's complement
    tmds_word_t word;

    // Transition minimisation, DC balancing and symbol selection
    always_comb begin
        n1d      = 4'($countones(data));
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
        acc      = data[0];
        qm       = '0;
        qm[0]    = acc;
        for (int i = 1; i < 8; i++) begin
            acc   = use_xnor ? ~(acc ^ data[i]) : (acc ^ data[i]);
            qm[i] = acc;
        end
        qm[8] = ~use_xnor;
        n1q   = 4'($countones(qm[7:0]));
        diff  = {n1q, 1'b0} - 5'd8;

        if ((cnt == 5'd0) || (n1q == 4'd4)) begin
            word   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_nx = qm[8] ? (cnt + diff) : (cnt - diff);
        end else if ((!cnt[4] && (n1q > 4'd4)) || (cnt[4] && (n1q < 4'd4))) begin
            word   = {1'b1, qm[8], ~qm[7:0]};
            cnt_nx = cnt + {3'b000, qm[8], 1'b0} - diff;
        end else begin
            word   = {1'b0, qm[8], qm[7:0]};
            cnt_nx = cnt + diff - {3'b000, ~qm[8], 1'b0};
        end

        // Guard override only ever replaces blanking symbols
        if (!de) begin
            cnt_nx = 5'd0;
            word   = (ovr == OVR_GUARD) ? guard_word : ctl_word(cd);
        end
    end

    // Output word and disparity registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmds <= TMDS_CTL_00;
            cnt  <= 5'd0;
        end else begin
            tmds <= word;
            cnt  <= cnt_nx;
        end
    end

endmodule

// File: rtl/hdmi_tmds_stream.sv
// Three-channel TMDS generator; HDMI_VIDEO_GUARD_EN adds preamble/guard insertion and blank_short.
// Latency: 2 cycles (12 with HDMI_VIDEO_GUARD_EN), identical for all channels and syncs.
// Backpressure: none; one word per channel every pixel clock.
module hdmi_tmds_stream
    import hdmi_pkg::*;
#(
    parameter int COLSPC = 8
) (
    input  logic              video_clk_pix,
    input  logic              video_rst_n,
    input  logic              video_enable,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [COLSPC-1:0] red,
    input  logic [COLSPC-1:0] green,
    input  logic [COLSPC-1:0] blue,
    output logic [9:0]        tmds_red,
    output logic [9:0]        tmds_green,
    output logic [9:0]        tmds_blue,
    output logic              blank_short
);

    if (COLSPC < 8) begin : g_colspc_check
        $error("hdmi_tmds_stream: COLSPC must be at least 8");
    end

    pix_t     in_q;
    pix_t     enc_in;
    ovr_sel_t ovr;
    logic [1:0] green_cd;
    logic     unused_lsbs;

    // Only the top 8 bits of each component are encoded
    assign unused_lsbs = ^{red, green, blue};

    // Input register
    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            in_q <= '0;
        end else begin
            in_q.de <= video_enable;
            in_q.hs <= hsync;
            in_q.vs <= vsync;
            in_q.r  <= red[COLSPC-1 -: 8];
            in_q.g  <= green[COLSPC-1 -: 8];
            in_q.b  <= blue[COLSPC-1 -: 8];
        end
    end

`ifdef HDMI_VIDEO_GUARD_EN
    pix_t       dly [LOOKAHEAD];
    logic       rise;
    logic       fall;
    logic       win_act;
    logic [3:0] win_pos;
    logic       cur_act;
    logic [3:0] cur_pos;
    logic [3:0] blank_cnt;
    logic       seen_active;
    logic       short_flag;

    // Lookahead line: the input register sees an enable edge LOOKAHEAD slots early
    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            for (int k = 0; k < LOOKAHEAD; k++) dly[k] <= '0;
        end else begin
            dly[0] <= in_q;
            for (int k = 1; k < LOOKAHEAD; k++) dly[k] <= dly[k-1];
        end
    end

    assign rise    = in_q.de & ~dly[0].de;
    assign fall    = ~in_q.de & dly[0].de;
    assign enc_in  = dly[LOOKAHEAD-1];
    // A new edge restarts the window at the slot now entering the encoders
    assign cur_act = rise | win_act;
    assign cur_pos = rise ? 4'd0 : win_pos;

    // Preamble for the first slots of the window, guard band for the last two
    always_comb begin
        ovr = OVR_NONE;
        if (cur_act && !enc_in.de) begin
            ovr = (cur_pos < 4'(PREAMBLE_LEN)) ? OVR_PREAMBLE : OVR_GUARD;
        end
    end

    // Window position tracker, one step per cycle after the edge
    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            win_act <= 1'b0;
            win_pos <= 4'd0;
        end else if (rise) begin
            win_act <= 1'b1;
            win_pos <= 4'd1;
        end else if (win_act) begin
            if (win_pos == 4'(LOOKAHEAD - 1)) begin
                win_act <= 1'b0;
            end else begin
                win_pos <= win_pos + 4'd1;
            end
        end
    end

    // Blanking-run length and sticky short-blank flag; first active period is exempt
    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            blank_cnt   <= 4'd0;
            seen_active <= 1'b0;
            short_flag  <= 1'b0;
        end else begin
            if (fall) begin
                blank_cnt <= 4'd1;
            end else if (!in_q.de && (blank_cnt < 4'(MIN_BLANK))) begin
                blank_cnt <= blank_cnt + 4'd1;
            end
            if (rise) begin
                seen_active <= 1'b1;
                if (seen_active && (blank_cnt < 4'(MIN_BLANK))) short_flag <= 1'b1;
            end
        end
    end

    assign blank_short = short_flag;
`else
    assign enc_in      = in_q;
    assign ovr         = OVR_NONE;
    assign blank_short = 1'b0;
`endif

    // Preamble signals video on channel 1 with CD = 01
    assign green_cd = (ovr == OVR_PREAMBLE) ? 2'b01 : 2'b00;

    tmds_channel_encoder u_enc_blue (
        .clk        (video_clk_pix),
        .rst_n      (video_rst_n),
        .data       (enc_in.b),
        .cd         ({enc_in.vs, enc_in.hs}),
        .de         (enc_in.de),
        .ovr        (ovr),
        .guard_word (TMDS_VGB_CH0),
        .tmds       (tmds_blue)
    );

    tmds_channel_encoder u_enc_green (
        .clk        (video_clk_pix),
        .rst_n      (video_rst_n),
        .data       (enc_in.g),
        .cd         (green_cd),
        .de         (enc_in.de),
        .ovr        (ovr),
        .guard_word (TMDS_VGB_CH1),
        .tmds       (tmds_green)
    );

    tmds_channel_encoder u_enc_red (
        .clk        (video_clk_pix),
        .rst_n      (video_rst_n),
        .data       (enc_in.r),
        .cd         (2'b00),
        .de         (enc_in.de),
        .ovr        (ovr),
        .guard_word (TMDS_VGB_CH2),
        .tmds       (tmds_red)
    );

endmodule
